cpu5_exu: RTL and testbench
===========================

Name: cpu5_exu

Overview:
- Execute stage of the cpu5 pipeline, directly downstream of the ALU control decoder. It consumes the 3-bit alucontrol code together with the operands and destination info.
- It performs the ALU operation and registers the result into the EX/MEM boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is a pure register output and back-pressure from MEM never creates a combinational ready path.

Parameters:
- XLEN, 32, operand/result width.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries (branch redirect).
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered.
- in_alucontrol  input  3  `CPU5_ALU_CONTROL_SIZE code from the ALU decoder.
- in_srca  input  XLEN  operand A.
- in_srcb  input  XLEN  operand B.
- in_rd  input  RD_W  destination register.
- in_regwrite  input  1  write-back enable.
- out_valid  output  1  result entry valid.
- out_ready  input  1  downstream accepts.
- out_result  output  XLEN  ALU result.
- out_zero  output  1  result == 0.
- out_illegal  output  1  alucontrol was an undefined code.
- out_rd  output  RD_W  destination register, passed through.
- out_regwrite  output  1  write-back enable, forced 0 when illegal.

Behaviour:
- Reset (async, active-high): main_valid=0, skid_valid=0, in_ready=1, out_valid=0. All data registers cleared: out_result=0, out_zero=0, out_illegal=0, out_rd=0, out_regwrite=0.
- ALU operations, evaluated combinationally on the in_* operands:
  - 000 AND.
  - 001 OR.
  - 010 ADD, modulo 2^XLEN, no carry out.
  - 110 SUB, modulo 2^XLEN.
  - 111 SLT, signed two's-complement compare; result is 1 or 0, zero-extended.
  - 011/100/101: result=0, illegal=1, regwrite forced 0.
- zero = (computed result == 0). It is computed before registering.
- Accept condition: in_valid && in_ready. Latency is 1 cycle from accept to out_valid.
- Handshake and buffering:
  - Main register drives the outputs. Output transfer happens when out_valid && out_ready.
  - Accept while main is empty, or while main is draining this cycle: the new entry goes to main.
  - Accept while main is full and not draining: the new entry goes to skid.
  - in_ready next = ~skid_valid_next.
  - When skid is full and main drains: main <= skid, skid empties. Order is preserved, skid data never overtakes main.
  - Skid full implies in_ready=0, so a third entry is never accepted.
- Data registers load only with their valid bit and hold otherwise. Output data is stable while out_valid && !out_ready.
- flush: next cycle main_valid=0, skid_valid=0, in_ready=1. An entry presented in the same cycle is dropped even though in_ready was 1. flush has priority over accept and drain. Data registers are not cleared.
- Simultaneous accept and drain with skid empty: the main register reloads, out_valid stays 1 (full throughput, 1 entry/cycle).
- A reset asserted mid-operation discards all entries immediately.

Decomposition:
- In defines.v:
  - `CPU5_XLEN=32
  - `CPU5_ALU_AND=3'b000, `CPU5_ALU_OR=3'b001, `CPU5_ALU_ADD=3'b010, `CPU5_ALU_SUB=3'b110, `CPU5_ALU_SLT=3'b111
  - existing `CPU5_ALU_CONTROL_SIZE.
- Sub-module cpu5_alu: purely combinational. Inputs a, b, alucontrol; outputs result, zero, illegal. Reused by the future branch-compare logic.
- cpu5_exu contains only the handshake/skid control and the registers.

Test Plan:
- ADD wrap: srca=0xFFFFFFFF, srcb=1, ctl=010, out_ready=1 -> next cycle out_valid=1, out_result=0, out_zero=1.
- SLT signed: srca=0xFFFFFFFF, srcb=1, ctl=111 -> out_result=1. Swap operands -> out_result=0, out_zero=1.
- Back-pressure:
  - Stimulus: out_ready=0, three consecutive in_valid entries (ADD 1+1, SUB 5-3, OR 4|1).
  - Response: first two accepted, in_ready=0 from cycle 2, third held.
  - Then raise out_ready: outputs appear in order 2, 2, 5, one per cycle, no loss or duplication.
- Illegal code: ctl=101, in_regwrite=1, rd=7 -> out_illegal=1, out_result=0, out_regwrite=0, out_rd=7.
- Flush: main and skid full, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, the presented entry is never output.
- Reset: assert reset asynchronously mid-cycle with out_valid=1 -> out_valid and in_ready reset values appear before the next clk edge, all data outputs read 0.

Source files
------------

// File: rtl/cpu5_exu_pkg.sv
// cpu5 execute-stage shared definitions: datapath widths and ALU control codes.
// Imported by cpu5_alu and cpu5_exu.
package cpu5_exu_pkg;

  localparam int unsigned CPU5_XLEN             = 32;
  localparam int unsigned CPU5_RD_W             = 5;
  localparam int unsigned CPU5_ALU_CONTROL_SIZE = 3;

  // Codes produced by the ALU control decoder; 011/100/101 are undefined.
  typedef enum logic [CPU5_ALU_CONTROL_SIZE-1:0] {
    CPU5_ALU_AND = 3'b000,
    CPU5_ALU_OR  = 3'b001,
    CPU5_ALU_ADD = 3'b010,
    CPU5_ALU_SUB = 3'b110,
    CPU5_ALU_SLT = 3'b111
  } alu_op_e;

endpackage

// File: rtl/cpu5_alu.sv
// cpu5 ALU: purely combinational, shared with the branch-compare path.
// Ports:
//   a, b        operands (XLEN)
//   alucontrol  3-bit operation code
//   result      operation result, 0 for undefined codes
//   zero        result == 0
//   illegal     alucontrol is not a defined operation
module cpu5_alu
  import cpu5_exu_pkg::*;
#(
  parameter int unsigned XLEN = CPU5_XLEN
) (
  input  logic [XLEN-1:0]                  a,
  input  logic [XLEN-1:0]                  b,
  input  logic [CPU5_ALU_CONTROL_SIZE-1:0] alucontrol,
  output logic [XLEN-1:0]                  result,
  output logic                             zero,
  output logic                             illegal
);

  // Operation select; undefined codes yield 0 and flag illegal.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_op_e'(alucontrol))
      CPU5_ALU_AND: result = a & b;
      CPU5_ALU_OR:  result = a | b;
      CPU5_ALU_ADD: result = a + b;
      CPU5_ALU_SUB: result = a - b;
      CPU5_ALU_SLT: result = XLEN'($signed(a) < $signed(b));
      default:      illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu5_exu.sv
// cpu5 execute stage: ALU plus EX/MEM register with a 2-entry skid buffer.
// in_ready is a pure register, so MEM back-pressure never reaches upstream
// combinationally.
// Ports:
//   clk, reset         clock, async active-high reset
//   flush              kill all held entries (branch redirect)
//   in_*               upstream entry: valid/ready, alucontrol, operands, rd, regwrite
//   out_*              downstream entry: valid/ready, result, zero, illegal, rd, regwrite
module cpu5_exu
  import cpu5_exu_pkg::*;
#(
  parameter int unsigned XLEN = CPU5_XLEN,
  parameter int unsigned RD_W = CPU5_RD_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CPU5_ALU_CONTROL_SIZE-1:0] in_alucontrol,
  input  logic [XLEN-1:0]                  in_srca,
  input  logic [XLEN-1:0]                  in_srcb,
  input  logic [RD_W-1:0]                  in_rd,
  input  logic                             in_regwrite,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  out_result,
  output logic                             out_zero,
  output logic                             out_illegal,
  output logic [RD_W-1:0]                  out_rd,
  output logic                             out_regwrite
);

  // Width depends on module parameters, so the payload type lives here.
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [RD_W-1:0] rd;
    logic            regwrite;
  } exu_entry_t;

  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_illegal;
  exu_entry_t      in_entry;
  exu_entry_t      main_q;
  exu_entry_t      skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic            main_valid_n;
  logic            skid_valid_n;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;
  logic            accept;
  logic            drain;

  cpu5_alu #(.XLEN(XLEN)) u_alu (
    .a          (in_srca),
    .b          (in_srcb),
    .alucontrol (in_alucontrol),
    .result     (alu_result),
    .zero       (alu_zero),
    .illegal    (alu_illegal)
  );

  // Illegal codes never write back.
  always_comb begin
    in_entry.result   = alu_result;
    in_entry.zero     = alu_zero;
    in_entry.illegal  = alu_illegal;
    in_entry.rd       = in_rd;
    in_entry.regwrite = in_regwrite & ~alu_illegal;
  end

  assign accept = in_valid & in_ready & ~flush;
  assign drain  = main_valid & out_ready;

  // Next occupancy and register load selects; flush overrides everything.
  always_comb begin
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        // in_ready is low while skid is full, so no accept can coincide.
        load_main_skid = 1'b1;
        skid_valid_n   = 1'b0;
      end else if (accept) begin
        load_main_in = 1'b1;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        load_skid    = 1'b1;
        skid_valid_n = 1'b1;
      end else begin
        load_main_in = 1'b1;
        main_valid_n = 1'b1;
      end
    end
  end

  // Occupancy, ready and payload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      in_ready   <= ~skid_valid_n;
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign out_valid    = main_valid;
  assign out_result   = main_q.result;
  assign out_zero     = main_q.zero;
  assign out_illegal  = main_q.illegal;
  assign out_rd       = main_q.rd;
  assign out_regwrite = main_q.regwrite;

endmodule

// File: tb/tb_cpu5_exu.sv
// Scoreboard bench for cpu5_exu: directed corner cases plus randomized traffic
// against an arithmetic reference model.
module tb_cpu5_exu;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_alucontrol;
  logic [31:0] in_srca;
  logic [31:0] in_srcb;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic [4:0]  out_rd;
  logic        out_regwrite;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [4:0]  rd;
    logic        regwrite;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  cpu5_exu dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alucontrol (in_alucontrol),
    .in_srca       (in_srca),
    .in_srcb       (in_srcb),
    .in_rd         (in_rd),
    .in_regwrite   (in_regwrite),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_illegal   (out_illegal),
    .out_rd        (out_rd),
    .out_regwrite  (out_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: arithmetic done in 64 bits then reduced modulo 2^32.
  function automatic exp_t model(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic rw);
    exp_t e;
    longint unsigned s;
    longint sa, sb;
    e.result  = 32'h0;
    e.illegal = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctl)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b010: begin
        s = longint'({32'h0, a}) + longint'({32'h0, b});
        e.result = 32'(s % 64'h1_0000_0000);
      end
      3'b110: begin
        s = 64'h1_0000_0000 + longint'({32'h0, a}) - longint'({32'h0, b});
        e.result = 32'(s % 64'h1_0000_0000);
      end
      3'b111: e.result = (sa < sb) ? 32'd1 : 32'd0;
      default: e.illegal = 1'b1;
    endcase
    e.zero     = (e.result == 32'h0);
    e.rd       = rd;
    e.regwrite = rw && !e.illegal;
    return e;
  endfunction

  // Stimulus side of the scoreboard: every accepted entry gets an expectation.
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready && !flush)
      sb_q.push_back(model(in_alucontrol, in_srca, in_srcb, in_rd, in_regwrite));
  end

  // Monitor: each output transfer is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got result 0x%0h with no entry expected", out_result);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_result", out_result, mon_e.result);
          check("sb_zero", out_zero, mon_e.zero);
          check("sb_illegal", out_illegal, mon_e.illegal);
          check("sb_rd", out_rd, mon_e.rd);
          check("sb_regwrite", out_regwrite, mon_e.regwrite);
        end
      end
      if (flush) sb_q.delete();
    end
  end

  task automatic drive(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw);
    in_valid      = 1'b1;
    in_alucontrol = ctl;
    in_srca       = a;
    in_srcb       = b;
    in_rd         = rd;
    in_regwrite   = rw;
  endtask

  // Hold the presented entry until accepted; returns #1 after the accepting edge.
  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw);
    drive(ctl, a, b, rd, rw);
    wait_accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_alucontrol = 3'b0;
    in_srca = 32'h0;
    in_srcb = 32'h0;
    in_rd = 5'h0;
    in_regwrite = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_regwrite", out_regwrite, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD wrap
    out_ready = 1'b1;
    issue(3'b010, 32'hFFFF_FFFF, 32'h1, 5'd3, 1'b1);
    check("add_wrap_valid", out_valid, 1);
    check("add_wrap_result", out_result, 0);
    check("add_wrap_zero", out_zero, 1);

    // SLT signed, both operand orders
    issue(3'b111, 32'hFFFF_FFFF, 32'h1, 5'd4, 1'b1);
    check("slt_neg_lt_pos", out_result, 1);
    issue(3'b111, 32'h1, 32'hFFFF_FFFF, 5'd4, 1'b1);
    check("slt_pos_lt_neg", out_result, 0);
    check("slt_pos_lt_neg_zero", out_zero, 1);
    @(posedge clk);
    #1;

    // Back-pressure: two accepted, third held, then in-order drain
    out_ready = 1'b0;
    check("bp_start_empty", out_valid, 0);
    drive(3'b010, 32'd1, 32'd1, 5'd1, 1'b1);
    @(negedge clk);
    check("bp_ready_c0", in_ready, 1);
    @(posedge clk);
    #1;
    drive(3'b110, 32'd5, 32'd3, 5'd2, 1'b1);
    @(negedge clk);
    check("bp_ready_c1", in_ready, 1);
    check("bp_valid_c1", out_valid, 1);
    @(posedge clk);
    #1;
    drive(3'b001, 32'd4, 32'd1, 5'd3, 1'b1);
    @(negedge clk);
    check("bp_ready_c2", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_ready_held", in_ready, 0);
      check("bp_result_stable", out_result, 2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", out_valid, 0);

    // Illegal code
    issue(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 1'b1);
    check("ill_illegal", out_illegal, 1);
    check("ill_result", out_result, 0);
    check("ill_regwrite", out_regwrite, 0);
    check("ill_rd", out_rd, 7);
    @(posedge clk);
    #1;

    // Flush with main and skid full and an entry presented
    out_ready = 1'b0;
    issue(3'b010, 32'd10, 32'd20, 5'd5, 1'b1);
    issue(3'b000, 32'hF0F0, 32'hFF00, 5'd6, 1'b1);
    drive(3'b001, 32'hAAAA, 32'h5555, 5'd9, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_nothing_out", out_valid, 0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid      = ($urandom % 4) != 0;
      in_alucontrol = 3'($urandom);
      in_srca       = (($urandom % 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      in_srcb       = (($urandom % 4) == 0) ? 32'h8000_0000 : $urandom;
      in_rd         = 5'($urandom);
      in_regwrite   = 1'($urandom);
      out_ready     = ($urandom % 3) != 0;
      flush         = ($urandom % 32) == 0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", 64'(sb_q.size()), 0);
    check("drain_out_valid", out_valid, 0);

    // Asynchronous reset mid-cycle with an entry held
    out_ready = 1'b0;
    issue(3'b010, 32'd7, 32'd8, 5'd11, 1'b1);
    check("pre_reset_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_result", out_result, 0);
    check("async_rst_zero", out_zero, 0);
    check("async_rst_illegal", out_illegal, 0);
    check("async_rst_rd", out_rd, 0);
    check("async_rst_regwrite", out_regwrite, 0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
